// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks DEPTH post-decode slots, detects hazards and selects operand sources.
// Define HAZARD_SCOREBOARD_FWD_EN for forwarding mode; otherwise every RAW dependence stalls until write-back.
module hazard_scoreboard #(
    parameter  int ADDR_W = 5,
    parameter  int DEPTH  = 3,
    parameter  int CNT_W  = 16,
    localparam int FWD_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [ADDR_W-1:0] rs1_d,
    input  logic [ADDR_W-1:0] rs2_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic [ADDR_W-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic              load_d,
    input  logic              pc_src_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [FWD_W-1:0]  fwd_a_e,
    output logic [FWD_W-1:0]  fwd_b_e,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DEPTH-1:0]  slot_vld_q, slot_vld_d;
    logic [DEPTH-1:0]  slot_wen_q, slot_wen_d;
    logic [DEPTH-1:0]  slot_ld_q, slot_ld_d;
    logic [ADDR_W-1:0] slot_rd_q [DEPTH];
    logic [ADDR_W-1:0] slot_rd_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              haz;
    logic              unused_retire;

    function automatic logic src_hit(input logic v, input logic w,
                                     input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] r);
        return v && w && (rd == r) && (r != '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        haz = 1'b0;
`ifdef HAZARD_SCOREBOARD_FWD_EN
        // Only a load in E cannot be forwarded in time; everything else is bypassed.
        haz = valid_d && slot_ld_q[0] &&
              ((use_rs1_d && src_hit(slot_vld_q[0], slot_wen_q[0], slot_rd_q[0], rs1_d)) ||
               (use_rs2_d && src_hit(slot_vld_q[0], slot_wen_q[0], slot_rd_q[0], rs2_d)));
`else
        // The write-back slot is excluded: the register file is write-first.
        for (int k = 0; k < DEPTH-1; k++) begin
            if (valid_d &&
                ((use_rs1_d && src_hit(slot_vld_q[k], slot_wen_q[k], slot_rd_q[k], rs1_d)) ||
                 (use_rs2_d && src_hit(slot_vld_q[k], slot_wen_q[k], slot_rd_q[k], rs2_d))))
                haz = 1'b1;
        end
`endif
    end

    assign stall_d   = haz && !pc_src_e;
    assign stall_f   = stall_d;
    assign flush_d   = pc_src_e;
    assign flush_e   = pc_src_e || haz;
    assign stall_cnt = cnt_q;

`ifdef HAZARD_SCOREBOARD_FWD_EN
    logic [ADDR_W-1:0] rs1_q, rs2_q;

    // Scan from the oldest slot down so the youngest matching producer wins.
    always_comb begin
        fwd_a_e = '0;
        fwd_b_e = '0;
        for (int k = DEPTH-1; k >= 1; k--) begin
            if (slot_vld_q[0] && src_hit(slot_vld_q[k], slot_wen_q[k], slot_rd_q[k], rs1_q))
                fwd_a_e = FWD_W'(k);
            if (slot_vld_q[0] && src_hit(slot_vld_q[k], slot_wen_q[k], slot_rd_q[k], rs2_q))
                fwd_b_e = FWD_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
    end

    assign unused_retire = slot_ld_q[DEPTH-1];
`else
    assign fwd_a_e = '0;
    assign fwd_b_e = '0;
    assign unused_retire = ^{slot_vld_q[DEPTH-1], slot_wen_q[DEPTH-1],
                             slot_ld_q[DEPTH-1], slot_rd_q[DEPTH-1]};
`endif

    always_comb begin
        slot_vld_d[0] = valid_d && !stall_d && !flush_e;
        slot_wen_d[0] = regwrite_d;
        slot_ld_d[0]  = load_d;
        slot_rd_d[0]  = rd_d;
        for (int k = 1; k < DEPTH; k++) begin
            slot_vld_d[k] = slot_vld_q[k-1];
            slot_wen_d[k] = slot_wen_q[k-1];
            slot_ld_d[k]  = slot_ld_q[k-1];
            slot_rd_d[k]  = slot_rd_q[k-1];
        end
        cnt_d = stall_d ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_q <= '0;
            cnt_q      <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_wen_q <= slot_wen_d;
        slot_ld_q  <= slot_ld_d;
        slot_rd_q  <= slot_rd_d;
    end

endmodule
